sm2201_isa_io_responder: RTL and testbench

ISA I/O-slave responder front-end of the SM2201 interface board: the target end of the ISA I/O cycles (ALE/IOR/IOW/AEN) a host issues into the 0x100–0x13F window. Decodes the window, converts each cycle into a single-cycle local-bus request toward the CAMAC-side logic, stretches the ISA cycle with CHRDY until the local side acknowledges, and drives read data back. A wait-state timeout protects the ISA bus against a dead local side.

---
 rtl/sm2201_isa_io_responder.sv | 144 ++++++++++++++
 tb/tb_sm2201_isa_io_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm2201_isa_io_responder.sv
// SM2201 ISA I/O-slave responder: decodes the 0x100-0x13F window and turns each ISA strobe into one local-bus access.
// Optional SM2201_ISA_TIMEOUT_IRQ_EN adds isa_irq_timeout, a flag raised when a local access times out.
module sm2201_isa_io_responder #(
  parameter logic [9:0]  BASE_ADDR    = 10'h100,
  parameter int unsigned WAIT_MAX     = 16,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
  input  logic       isa_clk,
  input  logic       isa_reset,
  input  logic [9:0] isa_addr,
  input  logic       isa_ale,
  input  logic       isa_aen,
  input  logic       isa_ior,
  input  logic       isa_iow,
  input  logic [7:0] isa_data_in,
  output logic [7:0] isa_data_out,
  output logic       isa_data_oe,
  output logic       isa_chrdy,
  output logic [5:0] loc_addr,
  output logic [7:0] loc_wdata,
  output logic       loc_rd,
  output logic       loc_wr,
  input  logic [7:0] loc_rdata,
  input  logic       loc_ack,
  output logic [7:0] timeout_cnt,
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
  output logic       isa_irq_timeout,
`endif
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, HOLD} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [9:0] addr_q;
  logic       ior_s1, ior_s2, ior_s3;
  logic       iow_s1, iow_s2, iow_s3;
  logic       op_rd;
  logic [7:0] wait_cnt;

  logic ior_fall, iow_fall, both_low, hit, strobe_high;

  assign ior_fall    = ior_s3 & ~ior_s2;
  assign iow_fall    = iow_s3 & ~iow_s2;
  assign both_low    = ~ior_s2 & ~iow_s2;
  assign hit         = (ior_fall | iow_fall) & ~isa_aen & (addr_q[9:6] == BASE_ADDR[9:6]);
  assign strobe_high = op_rd ? ior_s2 : iow_s2;

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      {ior_s1, ior_s2, ior_s3} <= '1;
      {iow_s1, iow_s2, iow_s3} <= '1;
      op_rd        <= 1'b0;
      wait_cnt     <= '0;
      isa_data_out <= '0;
      isa_data_oe  <= 1'b0;
      isa_chrdy    <= 1'b1;
      loc_addr     <= '0;
      loc_wdata    <= '0;
      loc_rd       <= 1'b0;
      loc_wr       <= 1'b0;
      timeout_cnt  <= '0;
      proto_err    <= 1'b0;
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
      isa_irq_timeout <= 1'b0;
`endif
    end else begin
      if (isa_ale) addr_q <= isa_addr;
      {ior_s3, ior_s2, ior_s1} <= {ior_s2, ior_s1, isa_ior};
      {iow_s3, iow_s2, iow_s1} <= {iow_s2, iow_s1, isa_iow};
      loc_rd <= 1'b0;
      loc_wr <= 1'b0;

      case (state)
        IDLE: begin
          // Overlapping strobes are a host protocol error and never reach the local bus.
          if (both_low) begin
            proto_err <= 1'b1;
          end else if (hit) begin
            state     <= REQ;
            isa_chrdy <= 1'b0;
            loc_addr  <= addr_q[5:0] - BASE_ADDR[5:0];
            op_rd     <= ior_fall;
            loc_rd    <= ior_fall;
            loc_wr    <= ~ior_fall;
            if (!ior_fall) loc_wdata <= isa_data_in;
          end
        end
        REQ: begin
          wait_cnt <= '0;
          if (strobe_high) begin
            state       <= IDLE;
            isa_chrdy   <= 1'b1;
            isa_data_oe <= 1'b0;
          end else begin
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (strobe_high) begin
            state       <= IDLE;
            isa_chrdy   <= 1'b1;
            isa_data_oe <= 1'b0;
          end else if (loc_ack) begin
            state     <= HOLD;
            isa_chrdy <= 1'b1;
            if (op_rd) begin
              isa_data_out <= loc_rdata;
              isa_data_oe  <= 1'b1;
            end
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
            isa_irq_timeout <= 1'b0;
`endif
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= HOLD;
            isa_chrdy <= 1'b1;
            if (op_rd) begin
              isa_data_out <= TIMEOUT_DATA;
              isa_data_oe  <= 1'b1;
            end
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
            isa_irq_timeout <= 1'b1;
`endif
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (strobe_high) begin
            state       <= IDLE;
            isa_data_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2201_isa_io_responder.sv
// Scoreboard bench for sm2201_isa_io_responder: host task drives ISA cycles, a local-side responder
// acknowledges with planned delays, and two monitors check local requests and ISA completions.
module tb_sm2201_isa_io_responder;

  localparam int unsigned WAIT_MAX = 16;
  localparam logic [7:0]  TO_DATA  = 8'hFF;

  logic       clk = 1'b0;
  logic       isa_reset;
  logic [9:0] isa_addr;
  logic       isa_ale, isa_aen, isa_ior, isa_iow;
  logic [7:0] isa_data_in, isa_data_out;
  logic       isa_data_oe, isa_chrdy;
  logic [5:0] loc_addr;
  logic [7:0] loc_wdata, loc_rdata, timeout_cnt;
  logic       loc_rd, loc_wr, loc_ack, proto_err;
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
  logic       isa_irq_timeout;
`endif

  always #5 clk = ~clk;

  sm2201_isa_io_responder #(
    .BASE_ADDR(10'h100), .WAIT_MAX(WAIT_MAX), .TIMEOUT_DATA(TO_DATA)
  ) dut (
    .isa_clk(clk), .isa_reset(isa_reset), .isa_addr(isa_addr), .isa_ale(isa_ale),
    .isa_aen(isa_aen), .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_data_in(isa_data_in),
    .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rd(loc_rd), .loc_wr(loc_wr),
    .loc_rdata(loc_rdata), .loc_ack(loc_ack), .timeout_cnt(timeout_cnt),
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
    .isa_irq_timeout(isa_irq_timeout),
`endif
    .proto_err(proto_err)
  );

  typedef struct { bit wr; logic [5:0] off; logic [7:0] wdata; } req_t;
  typedef struct { int delay; bit nochk; } plan_t;
  typedef struct { bit chk; bit rd; int len; logic [7:0] data; } rsp_t;

  req_t  req_q[$];
  plan_t plan_q[$];
  rsp_t  rsp_q[$];
  int    total = 0;
  int    bad = 0;
  int    exp_to = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request monitor: every local strobe must match the oldest expected access.
  req_t m1_r;
  always @(negedge clk) begin
    if (isa_reset && (loc_rd || loc_wr)) begin
      check("loc_strobe_expected", req_q.size() != 0, 1);
      if (req_q.size() != 0) begin
        m1_r = req_q.pop_front();
        check("loc_wr", loc_wr, m1_r.wr);
        check("loc_rd", loc_rd, !m1_r.wr);
        check("loc_addr", loc_addr, m1_r.off);
        if (m1_r.wr) check("loc_wdata", loc_wdata, m1_r.wdata);
      end
    end
  end

  // Completion monitor: each chrdy release is compared against the expected outcome.
  rsp_t m2_e;
  int   lowcnt = 0;
  bit   prev_chrdy = 1'b1;
  always @(negedge clk) begin
    if (!isa_chrdy) begin
      lowcnt++;
    end else if (!prev_chrdy) begin
      check("chrdy_release_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        m2_e = rsp_q.pop_front();
        if (m2_e.chk) check("chrdy_low_cycles", lowcnt, m2_e.len);
        if (m2_e.chk && m2_e.rd) begin
          check("rd_data", isa_data_out, m2_e.data);
          check("rd_oe", isa_data_oe, 1);
        end else begin
          check("oe_quiet", isa_data_oe, 0);
        end
      end
      lowcnt = 0;
    end
    prev_chrdy = isa_chrdy;
  end

  // Local-side responder: acks `delay` cycles after the strobe (0 = never).
  plan_t rp;
  rsp_t  rr;
  logic [7:0] rd_val;
  bit    acked;
  initial begin
    loc_ack = 1'b0;
    loc_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (isa_reset && (loc_rd || loc_wr)) begin
        check("plan_avail", plan_q.size() != 0, 1);
        if (plan_q.size() != 0) begin
          rp = plan_q.pop_front();
          rd_val = 8'($urandom);
          acked = (rp.delay >= 1) && (rp.delay <= int'(WAIT_MAX));
          rr.chk  = !rp.nochk;
          rr.rd   = loc_rd;
          rr.len  = acked ? rp.delay + 1 : int'(WAIT_MAX) + 1;
          rr.data = acked ? rd_val : TO_DATA;
          rsp_q.push_back(rr);
          if (!rp.nochk && !acked && exp_to < 255) exp_to++;
          if (rp.delay > 0) begin
            repeat (rp.delay) @(posedge clk);
            #1 loc_ack = 1'b1;
            loc_rdata = rd_val;
            @(posedge clk);
            #1 loc_ack = 1'b0;
            loc_rdata = 8'($urandom);
          end
        end
      end
    end
  end

  task automatic addr_phase(input logic [9:0] a, input bit aen);
    @(posedge clk); #1;
    isa_addr = a;
    isa_aen  = aen;
    isa_ale  = 1'b1;
    @(posedge clk); #1;
    isa_ale  = 1'b0;
    isa_addr = 10'($urandom);
  endtask

  task automatic isa_cycle(input logic [9:0] a, input bit rd, input logic [7:0] wd,
                           input bit aen, input int dly, input int abort_after);
    bit hit;
    int n;
    hit = !aen && (a[9:6] == 4'h4);
    if (hit) begin
      plan_q.push_back('{dly, abort_after != 0});
      req_q.push_back('{!rd, a[5:0], wd});
    end
    addr_phase(a, aen);
    if (!rd) isa_data_in = wd;
    @(posedge clk); #1;
    if (rd) isa_ior = 1'b0; else isa_iow = 1'b0;
    if (abort_after != 0) begin
      repeat (abort_after) @(posedge clk);
    end else begin
      repeat (6) @(negedge clk);
      n = 0;
      while (!isa_chrdy && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("chrdy_wait_bound", n < 200, 1);
      repeat (2) @(negedge clk);
      check("hold_oe", isa_data_oe, hit && rd);
      @(posedge clk);
    end
    #1;
    isa_ior = 1'b1;
    isa_iow = 1'b1;
    repeat (abort_after != 0 ? 24 : 6) @(posedge clk);
    @(negedge clk);
    check("oe_after_release", isa_data_oe, 0);
    check("chrdy_idle", isa_chrdy, 1);
    isa_aen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, dly;
    logic [9:0] a;
    isa_reset = 1'b0; isa_addr = '0; isa_ale = 1'b0; isa_aen = 1'b0;
    isa_ior = 1'b1; isa_iow = 1'b1; isa_data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_chrdy", isa_chrdy, 1);
    check("rst_oe", isa_data_oe, 0);
    check("rst_data_out", isa_data_out, 0);
    check("rst_loc_strobes", {loc_rd, loc_wr}, 0);
    check("rst_loc_addr", loc_addr, 0);
    check("rst_loc_wdata", loc_wdata, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    check("rst_proto_err", proto_err, 0);
    @(posedge clk); #1 isa_reset = 1'b1;
    repeat (3) @(posedge clk);

    isa_cycle(10'h105, 1, 8'h00, 0, 3, 0);
    isa_cycle(10'h13E, 0, 8'h18, 0, 2, 0);
    isa_cycle(10'h0F0, 1, 8'h00, 0, 1, 0);
    isa_cycle(10'h105, 1, 8'h00, 1, 1, 0);
    isa_cycle(10'h107, 1, 8'h00, 0, 1, 0);
    isa_cycle(10'h120, 1, 8'h00, 0, int'(WAIT_MAX), 0);
    isa_cycle(10'h121, 1, 8'h00, 0, int'(WAIT_MAX) + 1, 0);
    isa_cycle(10'h100, 1, 8'h00, 0, 0, 0);
    check("timeout_cnt_after_to", timeout_cnt, exp_to);
`ifdef SM2201_ISA_TIMEOUT_IRQ_EN
    check("irq_after_to", isa_irq_timeout, 1);
    isa_cycle(10'h102, 1, 8'h00, 0, 4, 0);
    check("irq_cleared", isa_irq_timeout, 0);
`endif

    // Overlapping IOR/IOW
    check("proto_err_before", proto_err, 0);
    addr_phase(10'h110, 0);
    @(posedge clk); #1 isa_ior = 1'b0; isa_iow = 1'b0;
    repeat (8) @(negedge clk);
    check("proto_err_set", proto_err, 1);
    check("proto_chrdy", isa_chrdy, 1);
    @(posedge clk); #1 isa_ior = 1'b1; isa_iow = 1'b1;
    repeat (6) @(posedge clk);
    isa_cycle(10'h111, 0, 8'h5C, 0, 2, 0);
    check("proto_err_sticky", proto_err, 1);

    // Host abort during WAIT_ACK; late ack must be ignored
    isa_cycle(10'h108, 1, 8'h00, 0, 12, 8);
    check("abort_timeout_cnt", timeout_cnt, exp_to);

    // Reset during WAIT_ACK
    plan_q.push_back('{0, 1'b1});
    req_q.push_back('{1'b0, 6'h02, 8'h00});
    addr_phase(10'h102, 0);
    @(posedge clk); #1 isa_ior = 1'b0;
    repeat (8) @(posedge clk);
    #1 isa_reset = 1'b0;
    #1;
    check("midrst_chrdy", isa_chrdy, 1);
    check("midrst_oe", isa_data_oe, 0);
    check("midrst_timeout_cnt", timeout_cnt, 0);
    check("midrst_proto_err", proto_err, 0);
    exp_to = 0;
    isa_ior = 1'b1;
    repeat (3) @(posedge clk);
    #1 isa_reset = 1'b1;
    repeat (4) @(posedge clk);
    isa_cycle(10'h101, 1, 8'h00, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(3, 0) != 0) ? {4'h4, 6'($urandom)} : 10'($urandom);
      r = $urandom_range(9, 0);
      dly = (r == 0) ? 0 : (r == 1) ? int'(WAIT_MAX) + 1 + $urandom_range(3, 0)
                                    : 1 + $urandom_range(int'(WAIT_MAX) - 1, 0);
      isa_cycle(a, 1'($urandom), 8'($urandom), $urandom_range(7, 0) == 0, dly, 0);
    end
    check("final_timeout_cnt", timeout_cnt, exp_to);
    check("final_req_q_empty", req_q.size(), 0);
    check("final_plan_q_empty", plan_q.size(), 0);
    check("final_rsp_q_empty", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
